// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and constants for the reset sequencer.
//   state_e  : sequencer state (HOLD, RELEASE, RUN)
//   CAUSE_*  : encodings reported on the cause output
//   CAUSE_W  : width of the cause field
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int CAUSE_W = 3;

  localparam logic [CAUSE_W-1:0] CAUSE_POR  = 3'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_BTN  = 3'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_SW   = 3'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_LOCK = 3'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_WDT  = 3'd4;

endpackage

// File: rtl/rst_debounce.sv
// -----------------------------------------------------------------------------
// rst_debounce
// Multi-flop synchroniser followed by an optional debouncer.
// With DEBOUNCE_CYCLES == 1 the block is a plain synchroniser: out_o is the
// last synchroniser flop, lagging async_i by SYNC_STAGES cycles.
// Otherwise out_o changes only after the synchronised input has disagreed with
// it for DEBOUNCE_CYCLES consecutive cycles; any agreement clears the count.
// Ports:
//   clk     in   clock
//   resetn  in   synchronous active-low reset (all flops to RESET_VAL, count 0)
//   async_i in   asynchronous input
//   out_o   out  synchronised (and debounced) level
// -----------------------------------------------------------------------------
module rst_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic async_i,
  output logic out_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!resetn) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES <= 1) begin : g_plain
    assign out_o = sync_s;
  end else begin : g_deb
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
      cnt_d = '0;
      deb_d = deb_q;
      if (sync_s != deb_q) begin
        // The edge ending the DEBOUNCE_CYCLES-th disagreeing cycle flips the
        // output; the count returns to zero, so it never wraps.
        if (cnt_q == CNT_LAST) deb_d = sync_s;
        else                   cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        cnt_q <= '0;
        deb_q <= RESET_VAL;
      end else begin
        cnt_q <= cnt_d;
        deb_q <= deb_d;
      end
    end

    assign out_o = deb_q;
  end

endmodule

// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
// Parametrised reset sequencer. Holds CHANNELS active-low resets until the PLL
// is locked and HOLD_CYCLES trigger-free cycles have elapsed, then releases
// channel 0 first and the rest every STAGE_GAP cycles. A debounced button,
// a software request, PLL lock loss or (optionally) watchdog expiry
// re-asserts every channel and records the cause.
// Optional feature: define RESET_SEQ_WDT_EN to enable the RUN-state watchdog.
// Ports:
//   clk         in   system clock
//   resetn      in   master reset, synchronous active-low
//   btn_n       in   asynchronous reset button, active-low
//   pll_locked  in   asynchronous PLL lock indicator
//   req         in   software reset request (single-cycle pulse)
//   wdt_kick    in   watchdog restart pulse (ignored without RESET_SEQ_WDT_EN)
//   rst_n       out  sequenced active-low resets, bit 0 released first
//   busy        out  high whenever not in RUN
//   cause       out  last reset cause (0 POR, 1 BTN, 2 SW, 3 LOCK, 4 WDT)
// -----------------------------------------------------------------------------
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int CHANNELS        = 3,
  parameter int HOLD_CYCLES     = 8,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int WDT_CYCLES      = 1024
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                btn_n,
  input  logic                pll_locked,
  input  logic                req,
  input  logic                wdt_kick,
  output logic [CHANNELS-1:0] rst_n,
  output logic                busy,
  output logic [CAUSE_W-1:0]  cause
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0]       GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [CHANNELS-1:0] FIRST_ON  = CHANNELS'(1);
  localparam logic [CHANNELS-1:0] ALL_ON    = '1;

  logic btn_d, lock_s, wdt_expire, trig;

  rst_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b1)
  ) u_btn (
    .clk    (clk),
    .resetn (resetn),
    .async_i(btn_n),
    .out_o  (btn_d)
  );

  // Lock only needs synchronising; a one-cycle debounce selects the bypass.
  rst_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(1),
    .RESET_VAL      (1'b0)
  ) u_lock (
    .clk    (clk),
    .resetn (resetn),
    .async_i(pll_locked),
    .out_o  (lock_s)
  );

  state_e               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [CHANNELS-1:0]  rst_q, rst_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic [CAUSE_W-1:0]   trig_cause;

`ifdef RESET_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_q, wdt_d;

  // Counts only in RUN; held at zero elsewhere and after a kick.
  always_comb begin
    wdt_d = '0;
    if (state_q == RUN && !wdt_kick && wdt_q != WDT_LAST) wdt_d = wdt_q + 1'b1;
  end

  assign wdt_expire = (state_q == RUN) && (wdt_q == WDT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) wdt_q <= '0;
    else         wdt_q <= wdt_d;
  end
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick | (WDT_CYCLES < 1);
  assign wdt_expire = 1'b0;
`endif

  assign trig = !btn_d || req || !lock_s || wdt_expire;

  // Priority when several triggers coincide: WDT > BTN > LOCK > SW.
  always_comb begin
    trig_cause = CAUSE_SW;
    if (wdt_expire)  trig_cause = CAUSE_WDT;
    else if (!btn_d) trig_cause = CAUSE_BTN;
    else if (!lock_s) trig_cause = CAUSE_LOCK;
  end

  // rst_q doubles as the release stage: it fills as a thermometer from bit 0,
  // so the channel to release next is the lowest zero bit.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    cause_d = cause_q;
    unique case (state_q)
      HOLD: begin
        rst_d = '0;
        gap_d = '0;
        if (trig) begin
          hold_d = '0;
          // Missing lock is the normal power-up condition, not a cause.
          if (wdt_expire)  cause_d = CAUSE_WDT;
          else if (!btn_d) cause_d = CAUSE_BTN;
          else if (req)    cause_d = CAUSE_SW;
        end else if (hold_q == HOLD_LAST) begin
          // Last qualifying cycle: channel 0 rises on this edge.
          hold_d  = '0;
          rst_d   = FIRST_ON;
          state_d = (FIRST_ON == ALL_ON) ? RUN : RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (trig) begin
          state_d = HOLD;
          hold_d  = '0;
          gap_d   = '0;
          rst_d   = '0;
          cause_d = trig_cause;
        end else if (state_q == RELEASE) begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            rst_d = (rst_q << 1) | FIRST_ON;
            if (rst_d == ALL_ON) state_d = RUN;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      rst_q   <= '0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
      cause_q <= cause_d;
    end
  end

  assign rst_n = rst_q;
  assign busy  = (state_q != RUN);
  assign cause = cause_q;

endmodule

// File: tb/tb_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_reset_seq
// Directed bench for reset_seq. Each step pushes the values the outputs must
// show at given future cycles; the cycle runner pops and compares them.
// Cycle n is the interval after the n-th rising edge; inputs written during
// cycle n are sampled on edge n+1.
// -----------------------------------------------------------------------------
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       resetn, btn_n, pll_locked, req, wdt_kick;
  logic [2:0] rst_n;
  logic       busy;
  logic [2:0] cause;

  bit kick_en = 1'b1;
  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       busy;
    logic [2:0] cause;
    string      tag;
  } exp_t;

  exp_t sb[$];

  reset_seq #(
    .CHANNELS       (3),
    .HOLD_CYCLES    (8),
    .STAGE_GAP      (4),
    .DEBOUNCE_CYCLES(16),
    .SYNC_STAGES    (2),
    .WDT_CYCLES     (32)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_n     (btn_n),
    .pll_locked(pll_locked),
    .req       (req),
    .wdt_kick  (wdt_kick),
    .rst_n     (rst_n),
    .busy      (busy),
    .cause     (cause)
  );

  always #5 clk = ~clk;

  // Periodic watchdog kick, gated by kick_en.
  initial begin
    wdt_kick = 1'b0;
    forever begin
      repeat (20) @(posedge clk);
      #2 wdt_kick = kick_en;
      @(posedge clk);
      #2 wdt_kick = 1'b0;
    end
  end

  task automatic expect_at(input int d, input logic [2:0] r, input logic b,
                           input logic [2:0] c, input string tag);
    exp_t e;
    e.cyc   = cyc + d;
    e.rst   = r;
    e.busy  = b;
    e.cause = c;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        assert (rst_n === e.rst) else begin
          failures++;
          $error("FAIL %s.rst_n cycle %0d got=%b exp=%b", e.tag, cyc, rst_n, e.rst);
        end
        checks++;
        assert (busy === e.busy) else begin
          failures++;
          $error("FAIL %s.busy cycle %0d got=%b exp=%b", e.tag, cyc, busy, e.busy);
        end
        checks++;
        assert (cause === e.cause) else begin
          failures++;
          $error("FAIL %s.cause cycle %0d got=%0d exp=%0d", e.tag, cyc, cause, e.cause);
        end
      end
    end
  endtask

  initial begin
    resetn = 1'b0; btn_n = 1'b1; pll_locked = 1'b1; req = 1'b0;

    // Power-on: reset state, then release sequence at 10/14/18.
    expect_at(3, 3'b000, 1'b1, 3'd0, "por_reset");
    run(3);
    resetn = 1'b1;
    expect_at(9,  3'b000, 1'b1, 3'd0, "por_pre0");
    expect_at(10, 3'b001, 1'b1, 3'd0, "por_ch0");
    expect_at(13, 3'b001, 1'b1, 3'd0, "por_pre1");
    expect_at(14, 3'b011, 1'b1, 3'd0, "por_ch1");
    expect_at(17, 3'b011, 1'b1, 3'd0, "por_pre2");
    expect_at(18, 3'b111, 1'b0, 3'd0, "por_run");
    run(20);

    // Short button press is filtered out.
    btn_n = 1'b0;
    expect_at(5,  3'b111, 1'b0, 3'd0, "btn_short_a");
    expect_at(15, 3'b111, 1'b0, 3'd0, "btn_short_b");
    expect_at(30, 3'b111, 1'b0, 3'd0, "btn_short_c");
    run(10);
    btn_n = 1'b1;
    run(20);

    // Long press: reset 19 cycles after press, held until debounced release.
    btn_n = 1'b0;
    expect_at(18, 3'b111, 1'b0, 3'd0, "btn_pre");
    expect_at(19, 3'b000, 1'b1, 3'd1, "btn_assert");
    expect_at(57, 3'b000, 1'b1, 3'd1, "btn_held");
    expect_at(65, 3'b000, 1'b1, 3'd1, "btn_pre0");
    expect_at(66, 3'b001, 1'b1, 3'd1, "btn_ch0");
    expect_at(69, 3'b001, 1'b1, 3'd1, "btn_pre1");
    expect_at(70, 3'b011, 1'b1, 3'd1, "btn_ch1");
    expect_at(73, 3'b011, 1'b1, 3'd1, "btn_pre2");
    expect_at(74, 3'b111, 1'b0, 3'd1, "btn_run");
    run(40);
    btn_n = 1'b1;
    run(36);

    // Software request.
    req = 1'b1;
    expect_at(1,  3'b000, 1'b1, 3'd2, "sw_assert");
    expect_at(8,  3'b000, 1'b1, 3'd2, "sw_pre0");
    expect_at(9,  3'b001, 1'b1, 3'd2, "sw_ch0");
    expect_at(16, 3'b011, 1'b1, 3'd2, "sw_ch1");
    expect_at(17, 3'b111, 1'b0, 3'd2, "sw_run");
    run(1);
    req = 1'b0;
    run(21);

    // Request coincides with synchronised lock loss: LOCK wins over SW.
    pll_locked = 1'b0;
    expect_at(2,  3'b111, 1'b0, 3'd2, "prio_pre");
    expect_at(3,  3'b000, 1'b1, 3'd3, "prio_lock");
    expect_at(11, 3'b001, 1'b1, 3'd3, "prio_ch0");
    expect_at(19, 3'b111, 1'b0, 3'd3, "prio_run");
    run(1);
    pll_locked = 1'b1;
    run(1);
    req = 1'b1;
    run(1);
    req = 1'b0;
    run(19);

    // One-cycle lock drop during RELEASE: reset 3 cycles later, cause LOCK.
    req = 1'b1;
    expect_at(1,  3'b000, 1'b1, 3'd2, "lr_sw");
    expect_at(9,  3'b001, 1'b1, 3'd2, "lr_ch0");
    expect_at(12, 3'b001, 1'b1, 3'd2, "lr_pre");
    expect_at(13, 3'b000, 1'b1, 3'd3, "lr_assert");
    expect_at(20, 3'b000, 1'b1, 3'd3, "lr_pre0");
    expect_at(21, 3'b001, 1'b1, 3'd3, "lr_ch0b");
    expect_at(29, 3'b111, 1'b0, 3'd3, "lr_run");
    run(1);
    req = 1'b0;
    run(9);
    pll_locked = 1'b0;
    run(1);
    pll_locked = 1'b1;
    run(21);

    // Lock drop during HOLD restarts the count and leaves cause alone.
    req = 1'b1;
    expect_at(1,  3'b000, 1'b1, 3'd2, "lh_sw");
    expect_at(13, 3'b000, 1'b1, 3'd2, "lh_restart");
    expect_at(14, 3'b001, 1'b1, 3'd2, "lh_ch0");
    expect_at(22, 3'b111, 1'b0, 3'd2, "lh_run");
    run(1);
    req = 1'b0;
    run(2);
    pll_locked = 1'b0;
    run(1);
    pll_locked = 1'b1;
    run(21);

    // Master reset pulse mid-RELEASE: POR values next edge, full sequence.
    req = 1'b1;
    expect_at(9,  3'b001, 1'b1, 3'd2, "rr_ch0");
    expect_at(11, 3'b001, 1'b1, 3'd2, "rr_pre");
    expect_at(12, 3'b000, 1'b1, 3'd0, "rr_por");
    expect_at(21, 3'b000, 1'b1, 3'd0, "rr_pre0");
    expect_at(22, 3'b001, 1'b1, 3'd0, "rr_ch0b");
    expect_at(26, 3'b011, 1'b1, 3'd0, "rr_ch1");
    expect_at(30, 3'b111, 1'b0, 3'd0, "rr_run");
    run(1);
    req = 1'b0;
    run(10);
    resetn = 1'b0;
    run(1);
    resetn = 1'b1;
    run(21);

`ifdef RESET_SEQ_WDT_EN
    // No kicks: expiry 32 cycles after RUN entry, cause WDT.
    kick_en = 1'b0;
    req = 1'b1;
    expect_at(17, 3'b111, 1'b0, 3'd2, "wdt_run");
    expect_at(48, 3'b111, 1'b0, 3'd2, "wdt_pre");
    expect_at(49, 3'b000, 1'b1, 3'd4, "wdt_expire");
    expect_at(65, 3'b111, 1'b0, 3'd4, "wdt_rerun");
    run(1);
    req = 1'b0;
    run(51);
    kick_en = 1'b1;
    run(14);
    // Regular kicks keep RUN alive.
    for (int k = 1; k <= 5; k++) expect_at(100 * k, 3'b111, 1'b0, 3'd4, "wdt_kicked");
    run(500);
`else
    // Watchdog absent: RUN persists indefinitely.
    for (int k = 1; k <= 5; k++) expect_at(200 * k, 3'b111, 1'b0, 3'd0, "no_wdt");
    run(1000);
`endif

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain pending=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
